reverser_seq: RTL and testbench

Burst sequencer for the combinational bit-reverser datapath (2**N-bit x, select s, out).
- Accepts a burst command: mode and word count.
- Streams input words through one reverser instance using valid/ready handshakes on both sides.
- Computes the per-word select s, registers the result, and reports progress.
- Sits between a word source, such as a UART/switch capture front end, and the display/output consumer.

---
 rtl/reverser_pkg.sv | 26 ++
 rtl/reverser.sv | 26 ++
 rtl/reverser_seq.sv | 132 +++++++++++++
 tb/tb_reverser_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reverser_pkg.sv
// Shared types and defaults for the reverser burst sequencer.
package reverser_pkg;

    localparam int N_DEF     = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        PASS  = 2'b00,
        REV   = 2'b01,
        ALT_P = 2'b10,
        ALT_R = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Alternating modes are the ones with the upper mode bit set.
    function automatic logic is_alt(input mode_t m);
        return m[1];
    endfunction

endpackage

// File: rtl/reverser.sv
// Combinational bit-reverser: out = x when s = 0, bit-reversed x when s = 1.
module reverser
    import reverser_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2**N-1:0] x,
    input  logic            s,
    output logic [2**N-1:0] out
);

    localparam int W = 2**N;

    logic [W-1:0] x_rev;

    // Mirror the word: bit i takes bit W-1-i.
    always_comb begin
        x_rev = '0;
        for (int i = 0; i < W; i++) begin
            x_rev[i] = x[W-1-i];
        end
    end

    assign out = s ? x_rev : x;

endmodule

// File: rtl/reverser_seq.sv
// Burst sequencer around one reverser: accepts a (mode, len) command, streams
// len words through the reverser with valid/ready on both sides, and pulses
// done when the last result has been taken by the consumer.
//
//  state | meaning
//  IDLE  | waiting for start; count holds last burst's value
//  RUN   | accepting words until remaining reaches 0
//  DRAIN | last result held until the consumer takes it
//  DONE  | one-cycle done pulse, then back to IDLE
module reverser_seq
    import reverser_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   len,
    input  logic [2**N-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2**N-1:0]    out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   count
);

    localparam int W = 2**N;
    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           state_q;
    mode_t            mode_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] count_q;
    logic             phase_q;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;

    logic             sel;
    logic [W-1:0]     rev_out;
    logic             accept;

    // in_ready looks at out_ready so a full output register can be refilled
    // in the same cycle it is emptied; it never looks at in_valid.
    assign in_ready = (state_q == RUN) && (remaining_q != '0) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Per-word reverser select from the captured mode and alternation phase.
    always_comb begin
        sel = 1'b0;
        case (mode_q)
            PASS:    sel = 1'b0;
            REV:     sel = 1'b1;
            default: sel = phase_q;
        endcase
    end

    reverser #(.N(N)) u_reverser (
        .x   (in_data),
        .s   (sel),
        .out (rev_out)
    );

    // Burst FSM with output register, counters and phase tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= PASS;
            remaining_q <= '0;
            count_q     <= '0;
            phase_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        if (len != '0) begin
                            mode_q      <= mode_t'(mode);
                            remaining_q <= len;
                            phase_q     <= mode[0];
                            state_q     <= RUN;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        out_data_q  <= rev_out;
                        out_valid_q <= 1'b1;
                        remaining_q <= remaining_q - ONE;
                        count_q     <= count_q + ONE;
                        if (is_alt(mode_q)) begin
                            phase_q <= ~phase_q;
                        end
                        if (remaining_q == ONE) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reverser_seq.sv
// Self-checking bench for reverser_seq: per-scenario tasks plus a scoreboard
// that predicts each result at input accept and compares it at output handoff.
module tb_reverser_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [7:0] len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int out_seen  = 0;

    logic [7:0] exp_q[$];
    logic [1:0] m_mode  = 2'b00;
    logic       m_phase = 1'b0;

    always #5 clk = ~clk;

    reverser_seq #(.N(3), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Scoreboard: compare on output handoff, predict on input accept.
    always @(negedge clk) begin
        logic       s;
        logic [7:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_seen++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected got %h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) $display("FAIL sb_data got %h exp %h", out_data, e);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                s = (m_mode == 2'b00) ? 1'b0 : (m_mode == 2'b01) ? 1'b1 : m_phase;
                exp_q.push_back(s ? rev8(in_data) : in_data);
                if (m_mode[1]) m_phase = ~m_phase;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [1:0] md, input logic [7:0] ln);
        @(posedge clk); #1;
        start = 1'b1; mode = md; len = ln;
        m_mode = md; m_phase = md[0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one word and hold it until accepted; returns at edge+1 after accept.
    task automatic feed(input logic [7:0] w);
        bit ok = 0;
        in_data = w; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total_cnt++;
            $display("FAIL feed_timeout word %h not accepted in 50 cycles", w);
        end
    endtask

    task automatic wait_done(input int bound, output bit seen, output bit ov_seen);
        seen = 0; ov_seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
            if (done) seen = 1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 8'h00) $display("FAIL rst_out_data got %h exp 00", out_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (count !== 8'd0) $display("FAIL rst_count got %0d exp 0", count); else pass_cnt++;
    endtask

    task automatic test_pass;
        bit seen, ov;
        logic [7:0] words [2] = '{8'hF0, 8'h3C};
        out_ready = 1'b1;
        do_start(2'b00, 8'd2);
        foreach (words[k]) begin
            feed(words[k]);
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL pass_latency word %0d out_valid got %b exp 1", k, out_valid); else pass_cnt++;
            total_cnt++; if (out_data !== words[k]) $display("FAIL pass_data word %0d got %h exp %h", k, out_data, words[k]); else pass_cnt++;
        end
        wait_done(10, seen, ov);
        total_cnt++; if (!seen) $display("FAIL pass_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (count !== 8'd2) $display("FAIL pass_count got %0d exp 2", count); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL pass_done_width got %b exp 0", done); else pass_cnt++;
    endtask

    task automatic test_rev;
        bit seen, ov;
        out_ready = 1'b1;
        do_start(2'b01, 8'd1);
        total_cnt++; if (busy !== 1'b1) $display("FAIL rev_busy_start got %b exp 1", busy); else pass_cnt++;
        feed(8'hF0);
        total_cnt++; if (out_data !== 8'h0F) $display("FAIL rev_data got %h exp 0F", out_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rev_busy_drain got %b exp 1", busy); else pass_cnt++;
        wait_done(10, seen, ov);
        total_cnt++; if (!seen) $display("FAIL rev_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rev_busy_at_done got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (count !== 8'd1) $display("FAIL rev_count got %0d exp 1", count); else pass_cnt++;
    endtask

    task automatic test_alt(input logic [1:0] md, input logic [7:0] e0, input logic [7:0] e1);
        bit seen, ov;
        out_ready = 1'b1;
        do_start(md, 8'd4);
        for (int k = 0; k < 4; k++) begin
            feed(8'hA1);
            total_cnt++;
            if (out_data !== ((k % 2 == 0) ? e0 : e1))
                $display("FAIL alt_data mode %b word %0d got %h exp %h", md, k, out_data, (k % 2 == 0) ? e0 : e1);
            else pass_cnt++;
        end
        wait_done(10, seen, ov);
        total_cnt++; if (!seen) $display("FAIL alt_done mode %b got 0 exp 1", md); else pass_cnt++;
        total_cnt++; if (count !== 8'd4) $display("FAIL alt_count got %0d exp 4", count); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        bit seen, ov;
        int seen_before;
        out_ready = 1'b0;
        seen_before = out_seen;
        do_start(2'b01, 8'd3);
        feed(8'h01);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b exp 0", c, in_ready); else pass_cnt++;
            total_cnt++; if (out_data !== 8'h80) $display("FAIL bp_hold cycle %0d got %h exp 80", c, out_data); else pass_cnt++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        feed(8'h02);
        feed(8'h03);
        wait_done(10, seen, ov);
        total_cnt++; if (!seen) $display("FAIL bp_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (out_seen - seen_before !== 3) $display("FAIL bp_delivered got %0d exp 3", out_seen - seen_before); else pass_cnt++;
        total_cnt++; if (exp_q.size() !== 0) $display("FAIL bp_leftover got %0d exp 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_len0;
        bit seen, ov;
        out_ready = 1'b1;
        do_start(2'b01, 8'd0);
        wait_done(4, seen, ov);
        total_cnt++; if (!seen) $display("FAIL len0_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (ov) $display("FAIL len0_out_valid got 1 exp 0"); else pass_cnt++;
        total_cnt++; if (count !== 8'd0) $display("FAIL len0_count got %0d exp 0", count); else pass_cnt++;
        // A start pulse in RUN (with different mode/len) must not disturb the burst.
        do_start(2'b01, 8'd2);
        feed(8'h12);
        start = 1'b1; mode = 2'b00; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        feed(8'h34);
        total_cnt++; if (out_data !== 8'h2C) $display("FAIL run_start_mode got %h exp 2C", out_data); else pass_cnt++;
        wait_done(10, seen, ov);
        total_cnt++; if (!seen) $display("FAIL run_start_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (count !== 8'd2) $display("FAIL run_start_count got %0d exp 2", count); else pass_cnt++;
        @(negedge clk); @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL run_start_idle busy got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit seen, ov;
        out_ready = 1'b1;
        do_start(2'b00, 8'd4);
        feed(8'h11);
        feed(8'h22);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (count !== 8'd0) $display("FAIL midrst_count got %0d exp 0", count); else pass_cnt++;
        wait_done(5, seen, ov);
        total_cnt++; if (seen) $display("FAIL midrst_no_done got 1 exp 0"); else pass_cnt++;
        do_start(2'b01, 8'd2);
        feed(8'h0E);
        total_cnt++; if (out_data !== 8'h70) $display("FAIL fresh_data got %h exp 70", out_data); else pass_cnt++;
        feed(8'hC3);
        wait_done(10, seen, ov);
        total_cnt++; if (!seen) $display("FAIL fresh_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (count !== 8'd2) $display("FAIL fresh_count got %0d exp 2", count); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 2'b00; len = 8'd0;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        test_reset;
        test_pass;
        test_rev;
        test_alt(2'b10, 8'hA1, 8'h85);
        test_alt(2'b11, 8'h85, 8'hA1);
        test_backpressure;
        test_len0;
        test_reset_mid;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL final_leftover got %0d exp 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
